gpio_filter_ctrl: RTL and testbench

//  Per-channel input conditioning and event controller for NumIn asynchronous pins.
//  - Synchronises each pin and debounces it through one prim_filter_ctr per channel.
//  - Bypasses the debounce per channel under software control.
//  - Detects rising/falling edges on the conditioned level.
//  - Latches edge events into a sticky interrupt-state register with W1C clear, test-set
//    and a combined irq.
//  - Sits between the GPIO pads and the GPIO register block / PLIC.

---
 rtl/gpio_filter_pkg.sv | 15 +
 rtl/gpio_filter_chan.sv | 60 ++++++
 rtl/prim_filter_ctr.sv | 37 +++
 rtl/gpio_filter_ctrl.sv | 63 ++++++
 tb/tb_gpio_filter_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_filter_pkg.sv
// Shared types and constants for the GPIO input filter / event controller.
package gpio_filter_pkg;

  localparam int unsigned NumInDefault  = 8;
  localparam int unsigned CyclesDefault = 16;
  localparam int unsigned SyncStages    = 2;

  typedef logic [NumInDefault-1:0] gpio_vec_t;

  // The debounce counter needs at least two clocks of history to be meaningful.
  function automatic bit cycles_valid(int unsigned cycles);
    return cycles >= 2;
  endfunction

endpackage

// File: rtl/gpio_filter_chan.sv
// One GPIO input channel: synchroniser, debounce filter and edge detection.
// Edges are suppressed in the cycle the filter enable changes so that the jump
// between bypassed and stored level never looks like a pad event.
module gpio_filter_chan
  import gpio_filter_pkg::*;
#(
  parameter int unsigned Cycles = CyclesDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic filter_en_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  in_sync;
  logic                  filt_prev_q;
  logic                  en_prev_q;
  logic                  reconfig;

  // Bring the asynchronous pad into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], in_i};
    end
  end

  assign in_sync = sync_q[SyncStages-1];

  prim_filter_ctr #(
    .Cycles (Cycles)
  ) u_filter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (filter_en_i),
    .filter_i (in_sync),
    .filter_o (filt_o)
  );

  // Remember last cycle's level and filter enable for edge and reconfig detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_prev_q <= 1'b0;
      en_prev_q   <= 1'b0;
    end else begin
      filt_prev_q <= filt_o;
      en_prev_q   <= filter_en_i;
    end
  end

  assign reconfig = filter_en_i ^ en_prev_q;
  assign rise_o   = filt_o & ~filt_prev_q & ~reconfig;
  assign fall_o   = ~filt_o & filt_prev_q & ~reconfig;

endmodule

// File: rtl/prim_filter_ctr.sv
// Debounce primitive: the stored level follows the input only after the input
// has differed from it for Cycles consecutive clocks. The counter always runs;
// enable_i only selects between the stored level and the raw input.
module prim_filter_ctr #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic filter_i,
  output logic filter_o
);

  localparam int unsigned    CtrW   = $clog2(Cycles);
  localparam logic [CtrW-1:0] CtrMax = CtrW'(Cycles - 1);

  logic            stored_q;
  logic [CtrW-1:0] ctr_q;

  // Count clocks of disagreement with the stored level; commit on the Cycles-th one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stored_q <= 1'b0;
      ctr_q    <= '0;
    end else if (filter_i == stored_q) begin
      ctr_q    <= '0;
    end else if (ctr_q == CtrMax) begin
      stored_q <= filter_i;
      ctr_q    <= '0;
    end else begin
      ctr_q    <= ctr_q + CtrW'(1);
    end
  end

  assign filter_o = enable_i ? stored_q : filter_i;

endmodule

// File: rtl/gpio_filter_ctrl.sv
// GPIO input conditioning and event controller: per-channel debounce and edge
// detection feeding a sticky W1C interrupt-state register and a combined irq.
module gpio_filter_ctrl
  import gpio_filter_pkg::*;
#(
  parameter int unsigned NumIn  = NumInDefault,
  parameter int unsigned Cycles = CyclesDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] in_i,
  input  logic [NumIn-1:0] filter_en_i,
  input  logic [NumIn-1:0] rise_en_i,
  input  logic [NumIn-1:0] fall_en_i,
  input  logic [NumIn-1:0] intr_en_i,
  input  logic [NumIn-1:0] intr_clr_i,
  input  logic [NumIn-1:0] intr_test_i,
  output logic [NumIn-1:0] filt_o,
  output logic [NumIn-1:0] intr_state_o,
  output logic             intr_o
);

  if (!cycles_valid(Cycles)) begin : gen_bad_cycles
    $error("gpio_filter_ctrl: Cycles must be >= 2");
  end
  if (NumIn < 1 || NumIn > 32) begin : gen_bad_numin
    $error("gpio_filter_ctrl: NumIn must be in 1..32");
  end

  logic [NumIn-1:0] rise;
  logic [NumIn-1:0] fall;
  logic [NumIn-1:0] set;
  logic [NumIn-1:0] intr_state_q;

  for (genvar n = 0; n < NumIn; n++) begin : gen_chan
    gpio_filter_chan #(
      .Cycles (Cycles)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_i        (in_i[n]),
      .filter_en_i (filter_en_i[n]),
      .filt_o      (filt_o[n]),
      .rise_o      (rise[n]),
      .fall_o      (fall[n])
    );
  end

  assign set = (rise & rise_en_i) | (fall & fall_en_i) | intr_test_i;

  // Sticky event flags; a new event in the same cycle as a clear is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_state_q <= '0;
    end else begin
      intr_state_q <= (intr_state_q & ~intr_clr_i) | set;
    end
  end

  assign intr_state_o = intr_state_q;
  assign intr_o       = |(intr_state_q & intr_en_i);

endmodule

// File: tb/tb_gpio_filter_ctrl.sv
// Bench for gpio_filter_ctrl: directed scenarios followed by random pad traffic,
// all checked every cycle against a window-based reference model.
module tb_gpio_filter_ctrl;
  import gpio_filter_pkg::*;

  localparam int unsigned NumIn  = 8;
  localparam int unsigned Cycles = 16;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  gpio_vec_t in_i, filter_en_i, rise_en_i, fall_en_i, intr_en_i, intr_clr_i, intr_test_i;
  gpio_vec_t filt_o, intr_state_o;
  logic      intr_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  gpio_filter_ctrl #(
    .NumIn  (NumIn),
    .Cycles (Cycles)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_i         (in_i),
    .filter_en_i  (filter_en_i),
    .rise_en_i    (rise_en_i),
    .fall_en_i    (fall_en_i),
    .intr_en_i    (intr_en_i),
    .intr_clr_i   (intr_clr_i),
    .intr_test_i  (intr_test_i),
    .filt_o       (filt_o),
    .intr_state_o (intr_state_o),
    .intr_o       (intr_o)
  );

  // Reference model: pad samples delayed two clocks, a sliding window of the
  // last Cycles synchronised samples, and the registered event state.
  gpio_vec_t pad_hist[$];
  gpio_vec_t win_hist[$];
  gpio_vec_t m_stored, m_filt_prev, m_en_prev, m_state;

  task automatic modelReset();
    pad_hist.delete();
    pad_hist.push_back('0);
    pad_hist.push_back('0);
    win_hist.delete();
    m_stored    = '0;
    m_filt_prev = '0;
    m_en_prev   = '0;
    m_state     = '0;
  endtask

  function automatic gpio_vec_t modelFilt();
    return (filter_en_i & m_stored) | (~filter_en_i & pad_hist[1]);
  endfunction

  task automatic modelEdge();
    gpio_vec_t filt_now, stable, rise, fall, set;
    bit all_differ;
    filt_now = modelFilt();
    stable   = ~(filter_en_i ^ m_en_prev);
    rise     = filt_now & ~m_filt_prev & stable;
    fall     = ~filt_now & m_filt_prev & stable;
    set      = (rise & rise_en_i) | (fall & fall_en_i) | intr_test_i;
    m_state     = (m_state & ~intr_clr_i) | set;
    m_filt_prev = filt_now;
    m_en_prev   = filter_en_i;
    win_hist.push_front(pad_hist[1]);
    if (win_hist.size() > Cycles) void'(win_hist.pop_back());
    if (win_hist.size() == Cycles) begin
      for (int n = 0; n < NumIn; n++) begin
        all_differ = 1'b1;
        for (int i = 0; i < Cycles; i++) begin
          if (win_hist[i][n] == m_stored[n]) all_differ = 1'b0;
        end
        if (all_differ) m_stored[n] = ~m_stored[n];
      end
    end
    pad_hist.push_front(in_i);
    void'(pad_hist.pop_back());
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input gpio_vec_t in_v, input gpio_vec_t fen, input gpio_vec_t ren,
                               input gpio_vec_t fall_v, input gpio_vec_t ien, input gpio_vec_t clr,
                               input gpio_vec_t tst);
    in_i        = in_v;
    filter_en_i = fen;
    rise_en_i   = ren;
    fall_en_i   = fall_v;
    intr_en_i   = ien;
    intr_clr_i  = clr;
    intr_test_i = tst;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clk_i);
    checkOutput("model_filt_o", filt_o, modelFilt());
    checkOutput("model_intr_state_o", intr_state_o, m_state);
    checkOutput("model_intr_o", intr_o, |(m_state & intr_en_i));
    if (rst_ni) modelEdge();
    else modelReset();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_filt_o", filt_o, 8'h00);
    checkOutput("reset_intr_state_o", intr_state_o, 8'h00);
    checkOutput("reset_intr_o", intr_o, 1'b0);
    rst_ni = 1'b1;
    cycle();

    // Bypassed channels pass the synchronised pad after two clocks.
    applyStimulus(8'hFF, '0, '0, '0, '0, '0, '0);
    cycle();
    checkOutput("t1_filt_1clk", filt_o, 8'h00);
    cycle();
    checkOutput("t1_filt_2clk", filt_o, 8'hFF);
    applyStimulus(8'h00, '0, '0, '0, '0, '0, '0);
    repeat (4) cycle();

    // Filtered rising edge on channel 0: 18 clocks to filt_o, one more to the flag.
    applyStimulus(8'h00, 8'h01, 8'h01, '0, 8'h01, '0, '0);
    repeat (3) cycle();
    applyStimulus(8'h01, 8'h01, 8'h01, '0, 8'h01, '0, '0);
    repeat (17) cycle();
    checkOutput("t2_filt_17clk", filt_o[0], 1'b0);
    cycle();
    checkOutput("t2_filt_18clk", filt_o[0], 1'b1);
    checkOutput("t2_state_not_yet", intr_state_o[0], 1'b0);
    cycle();
    checkOutput("t2_state_set", intr_state_o[0], 1'b1);
    checkOutput("t2_intr_o", intr_o, 1'b1);

    // A 10-clock glitch must not pass the filter.
    applyStimulus(8'h00, 8'h01, 8'h01, '0, 8'h01, '0, '0);
    repeat (20) cycle();
    applyStimulus(8'h00, 8'h01, 8'h01, '0, 8'h01, 8'h01, '0);
    cycle();
    checkOutput("t3_cleared", intr_state_o, 8'h00);
    applyStimulus(8'h01, 8'h01, 8'h01, '0, 8'h01, '0, '0);
    repeat (10) cycle();
    applyStimulus(8'h00, 8'h01, 8'h01, '0, 8'h01, '0, '0);
    repeat (20) cycle();
    checkOutput("t3_glitch_filt", filt_o[0], 1'b0);
    checkOutput("t3_glitch_state", intr_state_o, 8'h00);

    // Switching channel 1 to bypass jumps the level without raising an event.
    applyStimulus(8'h00, 8'h03, 8'h03, '0, 8'h01, '0, '0);
    repeat (3) cycle();
    applyStimulus(8'h02, 8'h03, 8'h03, '0, 8'h01, '0, '0);
    repeat (5) cycle();
    checkOutput("t4_filt_held", filt_o[1], 1'b0);
    applyStimulus(8'h02, 8'h01, 8'h03, '0, 8'h01, '0, '0);
    #1;
    checkOutput("t4_filt_jump", filt_o[1], 1'b1);
    cycle();
    checkOutput("t4_no_event", intr_state_o[1], 1'b0);
    repeat (3) cycle();
    checkOutput("t4_no_event_later", intr_state_o[1], 1'b0);

    // Set wins over clear on channel 2; a lone clear then drops the bit.
    applyStimulus(8'h06, 8'h01, 8'h03, 8'h04, 8'h01, '0, '0);
    repeat (4) cycle();
    applyStimulus(8'h06, 8'h01, 8'h03, 8'h04, 8'h01, '0, 8'h04);
    cycle();
    checkOutput("t5_test_set", intr_state_o[2], 1'b1);
    applyStimulus(8'h02, 8'h01, 8'h03, 8'h04, 8'h01, '0, '0);
    repeat (2) cycle();
    checkOutput("t5_filt_fell", filt_o[2], 1'b0);
    applyStimulus(8'h02, 8'h01, 8'h03, 8'h04, 8'h01, 8'h04, '0);
    cycle();
    checkOutput("t5_set_wins", intr_state_o[2], 1'b1);
    cycle();
    checkOutput("t5_clear", intr_state_o[2], 1'b0);

    // Test strobe, irq masking and asynchronous reset.
    applyStimulus(8'h02, 8'h01, 8'h03, 8'h04, 8'h00, 8'hFF, '0);
    cycle();
    applyStimulus(8'h02, 8'h01, 8'h03, 8'h04, 8'h00, '0, 8'hA5);
    cycle();
    applyStimulus(8'h02, 8'h01, 8'h03, 8'h04, 8'h00, '0, '0);
    checkOutput("t6_state_a5", intr_state_o, 8'hA5);
    checkOutput("t6_irq_masked", intr_o, 1'b0);
    intr_en_i = 8'h01;
    #1;
    checkOutput("t6_irq_enabled", intr_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_filt", filt_o, 8'h00);
    checkOutput("t6_rst_state", intr_state_o, 8'h00);
    checkOutput("t6_rst_irq", intr_o, 1'b0);
    modelReset();

    // Pads held high across reset release take the full latency and raise events.
    applyStimulus(8'hFF, 8'hFF, 8'hFF, '0, 8'hFF, '0, '0);
    repeat (2) cycle();
    rst_ni = 1'b1;
    repeat (17) cycle();
    checkOutput("rel_filt_17clk", filt_o, 8'h00);
    cycle();
    checkOutput("rel_filt_18clk", filt_o, 8'hFF);
    cycle();
    checkOutput("rel_rise_events", intr_state_o, 8'hFF);

    // Random pad traffic and configuration changes, with one mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      gpio_vec_t flip, fen, ren, fal, ien, clr, tst;
      for (int n = 0; n < NumIn; n++) flip[n] = ($urandom_range(0, 11) == 0);
      fen = ($urandom_range(0, 29) == 0) ? filter_en_i ^ gpio_vec_t'($urandom) : filter_en_i;
      ren = ($urandom_range(0, 39) == 0) ? gpio_vec_t'($urandom) : rise_en_i;
      fal = ($urandom_range(0, 39) == 0) ? gpio_vec_t'($urandom) : fall_en_i;
      ien = ($urandom_range(0, 39) == 0) ? gpio_vec_t'($urandom) : intr_en_i;
      clr = ($urandom_range(0, 7) == 0) ? gpio_vec_t'($urandom) : '0;
      tst = ($urandom_range(0, 31) == 0) ? gpio_vec_t'($urandom) : '0;
      applyStimulus(in_i ^ flip, fen, ren, fal, ien, clr, tst);
      if (c == 300) begin
        rst_ni = 1'b0;
        #1;
        checkOutput("rand_rst_state", intr_state_o, 8'h00);
        checkOutput("rand_rst_irq", intr_o, 1'b0);
        modelReset();
        cycle();
        rst_ni = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
